// File: rtl/seg_pkg.sv
// Shared constants and helpers for the multi-digit scan driver.
package seg_pkg;

  localparam int NUM_DIGITS_DEF     = 4;
  localparam int REFRESH_DIV_DEF    = 50000;
  localparam int DEAD_CYCLES_DEF    = 2;
  localparam bit DIG_ACTIVE_LOW_DEF = 1'b1;

  // Widest display the driver supports; lz_mask works on this many nibbles.
  localparam int MAX_DIGITS = 8;

  // Bit k set means digit k is a leading zero: nibbles k..n-1 are all zero.
  // Digit 0 is never flagged so an all-zero value still shows one "0".
  function automatic logic [MAX_DIGITS-1:0] lz_mask(
    input logic [4*MAX_DIGITS-1:0] value,
    input int                      n
  );
    logic [MAX_DIGITS-1:0] mask;
    logic                  zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
      if (k < n) begin
        zero_above = zero_above & (value[4*k +: 4] == 4'h0);
        mask[k]    = zero_above;
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/seg_scan_mux_if.sv
// Display-value bus between the value producer and the scan driver.
interface seg_scan_mux_if
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = NUM_DIGITS_DEF
);

  logic [4*NUM_DIGITS-1:0] i_value;
  logic                    i_load;
  logic                    i_blank_lz;
  logic [3:0]              o_nibble;
  logic [NUM_DIGITS-1:0]   o_dig_en;

  modport master (
    output i_value, i_load, i_blank_lz,
    input  o_nibble, o_dig_en
  );

  modport slave (
    input  i_value, i_load, i_blank_lz,
    output o_nibble, o_dig_en
  );

endinterface

// File: rtl/scan_tick_gen.sv
// Slot counter and digit index for the scan driver; flags the dead-time
// window and the last cycle of a frame.
module scan_tick_gen
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS  = NUM_DIGITS_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF,
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEF,
  parameter int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  parameter int PCNT_W      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic             clk_in,
  input  logic             rst_in,
  output logic [IDX_W-1:0] idx,
  output logic             slot_act,
  output logic             frame_bnd
);

  localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(REFRESH_DIV - 1);
  localparam logic [PCNT_W-1:0] DEAD_V   = PCNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(NUM_DIGITS - 1);

  logic [PCNT_W-1:0] pcnt;
  logic              pcnt_last;

  assign pcnt_last = (pcnt == PCNT_MAX);

  // Advance the slot counter every cycle; step to the next digit on its wrap.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pcnt <= '0;
      idx  <= '0;
    end else if (pcnt_last) begin
      pcnt <= '0;
      idx  <= (idx == IDX_MAX) ? '0 : idx + IDX_W'(1);
    end else begin
      pcnt <= pcnt + PCNT_W'(1);
    end
  end

  assign slot_act  = (pcnt >= DEAD_V);
  assign frame_bnd = pcnt_last && (idx == IDX_MAX);

endmodule

// File: rtl/seg_scan_mux.sv
// Multi-digit scan driver feeding a registered 4-bit-to-7-segment encoder.
// Digit enables are delayed one extra cycle so they line up with the
// encoder's segment register.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = NUM_DIGITS_DEF,
  parameter int REFRESH_DIV    = REFRESH_DIV_DEF,
  parameter int DEAD_CYCLES    = DEAD_CYCLES_DEF,
  parameter bit DIG_ACTIVE_LOW = DIG_ACTIVE_LOW_DEF
) (
  input  logic          clk_in,
  input  logic          rst_in,
  seg_scan_mux_if.slave bus
);

  localparam int VAL_W = 4 * NUM_DIGITS;
  localparam int EXT_W = 4 * MAX_DIGITS;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [IDX_W-1:0]      idx_p0;
  logic                  slot_act_p0;
  logic                  frame_bnd_p0;
  logic [VAL_W-1:0]      shadow;
  logic [VAL_W-1:0]      frame;
  logic [EXT_W-1:0]      frame_ext;
  logic [MAX_DIGITS-1:0] lz_all;
  logic                  unused_lz;
  logic [NUM_DIGITS-1:0] blank_p0;
  logic [NUM_DIGITS-1:0] req_p0;
  logic [3:0]            nib_p1;
  logic [NUM_DIGITS-1:0] en_p1;
  logic [NUM_DIGITS-1:0] dig_en_p2;

  scan_tick_gen #(
    .NUM_DIGITS  (NUM_DIGITS),
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES),
    .IDX_W       (IDX_W)
  ) u_tick (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .idx       (idx_p0),
    .slot_act  (slot_act_p0),
    .frame_bnd (frame_bnd_p0)
  );

  // Capture every load so it is waiting for the next frame boundary.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      shadow <= '0;
    end else if (bus.i_load) begin
      shadow <= bus.i_value;
    end
  end

  // Swap the displayed value only between frames; a load on the boundary
  // cycle itself goes straight in so it is not delayed a whole frame.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame <= '0;
    end else if (frame_bnd_p0) begin
      frame <= bus.i_load ? bus.i_value : shadow;
    end
  end

  // Blanking follows what is on display, not what is pending.
  assign frame_ext = EXT_W'(frame);
  assign lz_all    = lz_mask(frame_ext, NUM_DIGITS);
  assign unused_lz = |(lz_all >> NUM_DIGITS);
  assign blank_p0  = bus.i_blank_lz ? lz_all[NUM_DIGITS-1:0] : '0;

  // One-hot, active-high request for the digit owning the current slot.
  always_comb begin
    req_p0 = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if ((idx_p0 == IDX_W'(k)) && slot_act_p0 && !blank_p0[k]) begin
        req_p0[k] = 1'b1;
      end
    end
  end

  // p0 -> p1: nibble to the encoder, enable request held back one stage.
  // p1 -> p2: enables leave aligned with the encoder's registered segments.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      nib_p1    <= 4'h0;
      en_p1     <= '0;
      dig_en_p2 <= DIG_OFF;
    end else begin
      nib_p1    <= frame[4*idx_p0 +: 4];
      en_p1     <= req_p0;
      dig_en_p2 <= en_p1 ^ DIG_OFF;
    end
  end

  assign bus.o_nibble = nib_p1;
  assign bus.o_dig_en = dig_en_p2;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Bench for seg_scan_mux: a 4-digit display with 8-cycle slots and 2 dead cycles.
module tb_seg_scan_mux;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int DC = 2;
  localparam int FR = ND * RD;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_scan_mux_if #(.NUM_DIGITS(ND)) bus ();

  seg_scan_mux #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .DEAD_CYCLES    (DC),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: time since reset drives everything.
  int          m_t;
  logic [15:0] m_frame;
  logic [15:0] m_shadow;
  int          m_req;
  logic [3:0]  exp_nib;
  logic [3:0]  exp_en;

  function automatic int slot_of(int t);
    return (t / RD) % ND;
  endfunction

  function automatic int pos_of(int t);
    return t % RD;
  endfunction

  function automatic logic [3:0] digit_of(logic [15:0] v, int s);
    return 4'((v >> (4 * s)) & 16'h000F);
  endfunction

  function automatic bit hidden(logic [15:0] v, int s, logic bl);
    return (s > 0) && (bl === 1'b1) && ((v >> (4 * s)) == 16'h0000);
  endfunction

  function automatic logic [3:0] en_pattern(int d);
    return (d < 0) ? 4'hF : ~(4'b0001 << d);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_t      <= 0;
      m_frame  <= 16'h0000;
      m_shadow <= 16'h0000;
      m_req    <= -1;
      exp_nib  <= 4'h0;
      exp_en   <= 4'hF;
    end else begin
      exp_nib <= digit_of(m_frame, slot_of(m_t));
      exp_en  <= en_pattern(m_req);
      m_req   <= (pos_of(m_t) >= DC && !hidden(m_frame, slot_of(m_t), bus.i_blank_lz))
                 ? slot_of(m_t) : -1;
      if (m_t % FR == FR - 1) m_frame <= bus.i_load ? bus.i_value : m_shadow;
      if (bus.i_load) m_shadow <= bus.i_value;
      m_t <= m_t + 1;
    end
  end

  task automatic test_reset();
    int first_e = -1;
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_dig_en !== 4'hF) begin n_bad++; $display("FAIL reset_hold o_dig_en got %h expected F", bus.o_dig_en); end
      n_cmp++; if (bus.o_nibble !== 4'h0) begin n_bad++; $display("FAIL reset_hold o_nibble got %h expected 0", bus.o_nibble); end
    end
    rst = 1'b0;
    for (int c = 1; c <= 3 * RD; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_nibble !== exp_nib) begin n_bad++; $display("FAIL reset_release o_nibble @%0t got %h expected %h", $time, bus.o_nibble, exp_nib); end
      n_cmp++; if (bus.o_dig_en !== exp_en) begin n_bad++; $display("FAIL reset_release o_dig_en @%0t got %h expected %h", $time, bus.o_dig_en, exp_en); end
      if (first_e < 0 && bus.o_dig_en === 4'hE) first_e = c;
    end
    n_cmp++; if (first_e != 4) begin n_bad++; $display("FAIL reset_release first_E_cycle got %0d expected 4", first_e); end
  endtask

  task automatic test_load_scan();
    int cnt_en[16];
    int cnt_nib[16];
    logic [3:0] en_tab[5]  = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hF};
    int         en_need[5] = '{6, 6, 6, 6, 8};
    logic [3:0] nib_tab[4] = '{4'h7, 4'hA, 4'h2, 4'h1};
    for (int i = 0; i < 16; i++) begin cnt_en[i] = 0; cnt_nib[i] = 0; end
    bus.i_blank_lz = 1'b0;
    bus.i_value    = 16'h12A7;
    bus.i_load     = 1'b1;
    for (int c = 0; c < 3 * FR; c++) begin
      @(negedge clk);
      bus.i_load = 1'b0;
      n_cmp++; if (bus.o_nibble !== exp_nib) begin n_bad++; $display("FAIL load_scan o_nibble @%0t got %h expected %h", $time, bus.o_nibble, exp_nib); end
      n_cmp++; if (bus.o_dig_en !== exp_en) begin n_bad++; $display("FAIL load_scan o_dig_en @%0t got %h expected %h", $time, bus.o_dig_en, exp_en); end
      if (c >= 2 * FR) begin
        cnt_en[bus.o_dig_en]++;
        cnt_nib[bus.o_nibble]++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (cnt_en[en_tab[i]] != en_need[i]) begin n_bad++; $display("FAIL load_scan en_%h_cycles got %0d expected %0d", en_tab[i], cnt_en[en_tab[i]], en_need[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (cnt_nib[nib_tab[i]] != RD) begin n_bad++; $display("FAIL load_scan nib_%h_cycles got %0d expected %0d", nib_tab[i], cnt_nib[nib_tab[i]], RD); end
    end
  endtask

  task automatic test_blanking();
    logic [15:0] vals[2] = '{16'h0035, 16'h0000};
    for (int v = 0; v < 2; v++) begin
      int bad_en = 0;
      int nz_nib = 0;
      int seen_e = 0;
      int seen_d = 0;
      bus.i_blank_lz = 1'b1;
      bus.i_value    = vals[v];
      bus.i_load     = 1'b1;
      for (int c = 0; c < 3 * FR; c++) begin
        @(negedge clk);
        bus.i_load = 1'b0;
        n_cmp++; if (bus.o_nibble !== exp_nib) begin n_bad++; $display("FAIL blank o_nibble @%0t got %h expected %h", $time, bus.o_nibble, exp_nib); end
        n_cmp++; if (bus.o_dig_en !== exp_en) begin n_bad++; $display("FAIL blank o_dig_en @%0t got %h expected %h", $time, bus.o_dig_en, exp_en); end
        if (c >= 2 * FR) begin
          if (bus.o_dig_en === 4'hE) seen_e = 1;
          else if (bus.o_dig_en === 4'hD) seen_d = 1;
          else if (bus.o_dig_en !== 4'hF) bad_en++;
          if (bus.o_nibble !== 4'h0) nz_nib++;
        end
      end
      n_cmp++; if (seen_e != 1) begin n_bad++; $display("FAIL blank digit0_shown value %h got %0d expected 1", vals[v], seen_e); end
      if (v == 0) begin
        n_cmp++; if (bad_en != 0) begin n_bad++; $display("FAIL blank stray_enables value %h got %0d expected 0", vals[v], bad_en); end
        n_cmp++; if (seen_d != 1) begin n_bad++; $display("FAIL blank digit1_shown value %h got %0d expected 1", vals[v], seen_d); end
      end else begin
        n_cmp++; if (bad_en + seen_d != 0) begin n_bad++; $display("FAIL blank zero_extra_enables got %0d expected 0", bad_en + seen_d); end
        n_cmp++; if (nz_nib != 0) begin n_bad++; $display("FAIL blank zero_nibbles got %0d nonzero expected 0", nz_nib); end
      end
    end
    bus.i_blank_lz = 1'b0;
  endtask

  task automatic test_mid_frame_load();
    logic [3:0] nibs[25];
    int found = 0;
    bus.i_blank_lz = 1'b0;
    bus.i_value    = 16'h1234;
    bus.i_load     = 1'b1;
    for (int c = 0; c < 3 * FR && found == 0; c++) begin
      @(negedge clk);
      bus.i_load = 1'b0;
      n_cmp++; if (bus.o_nibble !== exp_nib) begin n_bad++; $display("FAIL mid_load o_nibble @%0t got %h expected %h", $time, bus.o_nibble, exp_nib); end
      n_cmp++; if (bus.o_dig_en !== exp_en) begin n_bad++; $display("FAIL mid_load o_dig_en @%0t got %h expected %h", $time, bus.o_dig_en, exp_en); end
      if (c >= FR && m_t % FR == 2 * RD + 3) found = 1;
    end
    n_cmp++; if (found != 1) begin n_bad++; $display("FAIL mid_load slot2_reached got %0d expected 1", found); end
    bus.i_value = 16'hBEEF;
    bus.i_load  = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      bus.i_load = 1'b0;
      nibs[k] = bus.o_nibble;
      n_cmp++; if (bus.o_nibble !== exp_nib) begin n_bad++; $display("FAIL mid_load o_nibble @%0t got %h expected %h", $time, bus.o_nibble, exp_nib); end
      n_cmp++; if (bus.o_dig_en !== exp_en) begin n_bad++; $display("FAIL mid_load o_dig_en @%0t got %h expected %h", $time, bus.o_dig_en, exp_en); end
    end
    n_cmp++; if (nibs[1]  !== 4'h2) begin n_bad++; $display("FAIL mid_load slot2_kept got %h expected 2", nibs[1]); end
    n_cmp++; if (nibs[13] !== 4'h1) begin n_bad++; $display("FAIL mid_load slot3_kept got %h expected 1", nibs[13]); end
    n_cmp++; if (nibs[14] !== 4'hF) begin n_bad++; $display("FAIL mid_load new_digit0 got %h expected F", nibs[14]); end
    n_cmp++; if (nibs[22] !== 4'hE) begin n_bad++; $display("FAIL mid_load new_digit1 got %h expected E", nibs[22]); end
  endtask

  task automatic test_load_on_boundary();
    logic [3:0] nibs[3];
    int found = 0;
    for (int c = 0; c < 2 * FR && found == 0; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_nibble !== exp_nib) begin n_bad++; $display("FAIL boundary o_nibble @%0t got %h expected %h", $time, bus.o_nibble, exp_nib); end
      n_cmp++; if (bus.o_dig_en !== exp_en) begin n_bad++; $display("FAIL boundary o_dig_en @%0t got %h expected %h", $time, bus.o_dig_en, exp_en); end
      if (m_t % FR == FR - 1) found = 1;
    end
    n_cmp++; if (found != 1) begin n_bad++; $display("FAIL boundary reached got %0d expected 1", found); end
    bus.i_value = 16'h5555;
    bus.i_load  = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      bus.i_load = 1'b0;
      nibs[k] = bus.o_nibble;
    end
    n_cmp++; if (nibs[1] !== 4'hB) begin n_bad++; $display("FAIL boundary old_digit3 got %h expected B", nibs[1]); end
    n_cmp++; if (nibs[2] !== 4'h5) begin n_bad++; $display("FAIL boundary new_digit0 got %h expected 5", nibs[2]); end
    for (int c = 0; c < FR; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_nibble !== exp_nib) begin n_bad++; $display("FAIL boundary o_nibble @%0t got %h expected %h", $time, bus.o_nibble, exp_nib); end
      n_cmp++; if (bus.o_dig_en !== exp_en) begin n_bad++; $display("FAIL boundary o_dig_en @%0t got %h expected %h", $time, bus.o_dig_en, exp_en); end
    end
  endtask

  task automatic test_reset_mid_slot();
    int found   = 0;
    int first_e = -1;
    int nz_nib  = 0;
    for (int c = 0; c < 2 * FR && found == 0; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_nibble !== exp_nib) begin n_bad++; $display("FAIL reset_mid o_nibble @%0t got %h expected %h", $time, bus.o_nibble, exp_nib); end
      n_cmp++; if (bus.o_dig_en !== exp_en) begin n_bad++; $display("FAIL reset_mid o_dig_en @%0t got %h expected %h", $time, bus.o_dig_en, exp_en); end
      if (m_t % FR == 3 * RD + 4) found = 1;
    end
    n_cmp++; if (found != 1) begin n_bad++; $display("FAIL reset_mid slot3_reached got %0d expected 1", found); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.o_dig_en !== 4'hF) begin n_bad++; $display("FAIL reset_mid o_dig_en got %h expected F", bus.o_dig_en); end
    n_cmp++; if (bus.o_nibble !== 4'h0) begin n_bad++; $display("FAIL reset_mid o_nibble got %h expected 0", bus.o_nibble); end
    rst = 1'b0;
    for (int c = 1; c <= FR; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_nibble !== exp_nib) begin n_bad++; $display("FAIL reset_mid o_nibble @%0t got %h expected %h", $time, bus.o_nibble, exp_nib); end
      n_cmp++; if (bus.o_dig_en !== exp_en) begin n_bad++; $display("FAIL reset_mid o_dig_en @%0t got %h expected %h", $time, bus.o_dig_en, exp_en); end
      if (first_e < 0 && bus.o_dig_en === 4'hE) first_e = c;
      if (bus.o_nibble !== 4'h0) nz_nib++;
    end
    n_cmp++; if (first_e != 4) begin n_bad++; $display("FAIL reset_mid restart_E_cycle got %0d expected 4", first_e); end
    n_cmp++; if (nz_nib != 0) begin n_bad++; $display("FAIL reset_mid frame_cleared nonzero_nibbles got %0d expected 0", nz_nib); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      n_cmp++; if (bus.o_nibble !== exp_nib) begin n_bad++; $display("FAIL random o_nibble @%0t got %h expected %h", $time, bus.o_nibble, exp_nib); end
      n_cmp++; if (bus.o_dig_en !== exp_en) begin n_bad++; $display("FAIL random o_dig_en @%0t got %h expected %h", $time, bus.o_dig_en, exp_en); end
      bus.i_load  = ($urandom_range(0, 11) == 0);
      bus.i_value = 16'($urandom >> $urandom_range(16, 31));
      if ($urandom_range(0, 49) == 0) bus.i_blank_lz = ~bus.i_blank_lz;
      rst = ($urandom_range(0, 299) == 0);
    end
    rst        = 1'b0;
    bus.i_load = 1'b0;
  endtask

  initial begin
    bus.i_value    = '0;
    bus.i_load     = 1'b0;
    bus.i_blank_lz = 1'b0;
    rst            = 1'b1;
    test_reset();
    test_load_scan();
    test_blanking();
    test_mid_frame_load();
    test_load_on_boundary();
    test_reset_mid_slot();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
